player_ctrl: RTL and testbench
==============================

PLAYER_CTRL -- requirements
Module: player_ctrl

Interface
REQ-001 SHALL provide parameter MAZE_W, default 10, maze columns (x).
REQ-002 SHALL provide parameter MAZE_H, default 10, maze rows (y).
REQ-003 SHALL provide parameter DEB_CYCLES, default 65536, consecutive stable samples needed to accept a button level.
REQ-004 SHALL have the port: clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have the port: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have the port: maze  in  MAZE_W*MAZE_H  flat maze; bit y*MAZE_W+x is cell (x,y); 1 = wall, 0 = open.
REQ-007 SHALL have the port: start_pos  in  8  {x[7:4],y[3:0]} spawn cell.
REQ-008 SHALL have the port: end_pos  in  8  {x[7:4],y[3:0]} goal cell.
REQ-009 SHALL have the ports: btn_up, btn_down, btn_left, btn_right  in  1 each  raw asynchronous push-buttons, active-high.
REQ-010 SHALL have the port: player_pos  out  8  {x,y} current cell; feeds the display stage.
REQ-011 SHALL have the port: win  out  1  high while the player sits on end_pos.
REQ-012 SHALL have the port: move_count  out  10  accepted moves since reset, saturating.

Function
REQ-013 SHALL pass each button through a 2-flop synchroniser, then a debouncer that updates the clean level only after DEB_CYCLES consecutive equal samples.
REQ-014 SHALL produce a one-cycle press pulse on the rising edge of each clean level; releases and held buttons produce no pulse.
REQ-015 SHALL implement FSM states LOAD, IDLE, CHECK, COMMIT, WON.
REQ-016 LOAD: entered on reset release; player_pos <= start_pos; next state IDLE.
REQ-017 IDLE: on any press pulse, latch a direction and go to CHECK; if several pulses occur in the same cycle, priority is up > down > left > right, and the others are dropped.
REQ-018 SHALL treat up as y-1, down as y+1, left as x-1, right as x+1.
REQ-019 CHECK: compute the target cell; reject the move and return to IDLE if the target is off-grid (x=0 left, x=MAZE_W-1 right, y=0 up, y=MAZE_H-1 down) or the maze bit is 1; otherwise go to COMMIT.
REQ-020 SHALL compute target arithmetic in 4 bits with no wrap; the off-grid test SHALL precede the maze lookup.
REQ-021 COMMIT: update player_pos to the target and increment move_count, saturating at 1023; then go to WON if target==end_pos, else to IDLE.
REQ-022 Latency: a press pulse in cycle N produces an updated player_pos in cycle N+2.
REQ-023 Press pulses arriving in CHECK or COMMIT SHALL be dropped, not queued.
REQ-024 WON: win=1; all buttons ignored; player_pos and move_count hold; the FSM leaves WON only via reset.
REQ-025 win SHALL be registered and equal (state==WON).
REQ-026 If start_pos==end_pos, LOAD SHALL go directly to WON with move_count=0.
REQ-027 maze, start_pos and end_pos SHALL be treated as static between resets; changes outside LOAD/CHECK have no effect until used.

Reset
REQ-028 While reset is high: state=LOAD, player_pos=0, win=0, move_count=0, debouncer counters=0, clean levels=0, synchronisers=0.
REQ-029 A reset asserted mid-move (CHECK/COMMIT) SHALL abort the move immediately with no partial update.

Structure
REQ-030 The shared maze parameter package SHALL hold MAZE_W, MAZE_H, the flat-maze width, the 4-bit coordinate width, the 8-bit {x,y} packing, and the direction encoding.
REQ-031 SHALL contain one sub-module, btn_debounce (sync + debounce + edge pulse), instantiated four times.

Verification (DEB_CYCLES=4; maze = border walls plus a wall at (3,2))
REQ-032 Reset with start_pos=(1,1), end_pos=(8,8) -> player_pos=0 during reset, (1,1) one cycle after release; win=0; move_count=0.
REQ-033 From (1,1), press right (held 10 cycles) -> player_pos=(2,1) exactly DEB_CYCLES+2 sync+1 edge+2 cycles after assertion; move_count=1.
REQ-034 From (2,1), press down, then right -> (2,2); the right move is blocked by (3,2), so position stays (2,2) and move_count=2.
REQ-035 With MAZE_W-1=9 open (no right border) and player at (9,5), press right -> no move and no count; also a 2-cycle glitch on btn_up -> no move.
REQ-036 Press up and left in the same cycle at (2,2) -> (2,1) only.
REQ-037 Step to (8,8) -> win=1 in the COMMIT+1 cycle; further presses leave (8,8) and the count unchanged; reset -> win=0 and position back at start.

Source files
------------

// File: rtl/player_ctrl_pkg.sv
// Shared maze geometry, {x,y} cell packing, move directions and controller states.
package player_ctrl_pkg;

  localparam int MAZE_W    = 10;
  localparam int MAZE_H    = 10;
  localparam int MAZE_BITS = MAZE_W * MAZE_H;
  localparam int COORD_W   = 4;
  localparam int POS_W     = 2 * COORD_W;
  localparam int MOVES_W   = 10;

  localparam logic [MOVES_W-1:0] MOVES_MAX = '1;

  // Field order matches the {x[7:4], y[3:0]} byte used on the ports.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pos_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_WON    = 3'd4
  } state_e;

endpackage

// File: rtl/player_ctrl_btn_debounce.sv
// Push-button conditioning: 2-flop synchroniser, DEB_CYCLES-sample debouncer and a
// registered one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
  parameter int DEB_CYCLES = 65536
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             prev_q;
  logic             press_q, press_d;

  // The counter tracks consecutive samples that disagree with the accepted level;
  // any agreeing sample restarts the count, so short glitches never get through.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_q & ~prev_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/player_ctrl.sv
// Maze player controller: debounced buttons step the player through open cells until the goal.
// A press pulse in cycle N shows the new position in cycle N+2; pulses during a move are dropped.
module player_ctrl
  import player_ctrl_pkg::pos_t, player_ctrl_pkg::dir_e, player_ctrl_pkg::state_e,
         player_ctrl_pkg::DIR_UP, player_ctrl_pkg::DIR_DOWN, player_ctrl_pkg::DIR_LEFT,
         player_ctrl_pkg::DIR_RIGHT, player_ctrl_pkg::ST_LOAD, player_ctrl_pkg::ST_IDLE,
         player_ctrl_pkg::ST_CHECK, player_ctrl_pkg::ST_COMMIT, player_ctrl_pkg::ST_WON,
         player_ctrl_pkg::COORD_W, player_ctrl_pkg::POS_W, player_ctrl_pkg::MOVES_W,
         player_ctrl_pkg::MOVES_MAX;
#(
  parameter int MAZE_W     = player_ctrl_pkg::MAZE_W,
  parameter int MAZE_H     = player_ctrl_pkg::MAZE_H,
  parameter int DEB_CYCLES = 65536
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [MAZE_W*MAZE_H-1:0] maze,
  input  logic [POS_W-1:0]         start_pos,
  input  logic [POS_W-1:0]         end_pos,
  input  logic                     btn_up,
  input  logic                     btn_down,
  input  logic                     btn_left,
  input  logic                     btn_right,
  output logic [POS_W-1:0]         player_pos,
  output logic                     win,
  output logic [MOVES_W-1:0]       move_count
);

  localparam int CELLS = MAZE_W * MAZE_H;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(MAZE_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(MAZE_H - 1);

  logic p_up, p_down, p_left, p_right;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .reset(reset), .btn_i(btn_up), .press_o(p_up)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk(clk), .reset(reset), .btn_i(btn_down), .press_o(p_down)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
    .clk(clk), .reset(reset), .btn_i(btn_left), .press_o(p_left)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
    .clk(clk), .reset(reset), .btn_i(btn_right), .press_o(p_right)
  );

  state_e             state_q, state_d;
  dir_e               dir_q, dir_d;
  pos_t               pos_q, pos_d;
  logic [MOVES_W-1:0] cnt_q, cnt_d;
  logic               win_q;

  pos_t        tgt;
  logic        off_grid;
  logic        wall;
  logic [15:0] lin;

  // The edge test is resolved before any arithmetic is trusted, so a 4-bit
  // wrap of the target never reaches the maze lookup.
  always_comb begin
    tgt      = pos_q;
    off_grid = 1'b0;
    case (dir_q)
      DIR_UP: begin
        off_grid = (pos_q.y == '0);
        tgt.y    = pos_q.y - 1'b1;
      end
      DIR_DOWN: begin
        off_grid = (pos_q.y == Y_LAST);
        tgt.y    = pos_q.y + 1'b1;
      end
      DIR_LEFT: begin
        off_grid = (pos_q.x == '0);
        tgt.x    = pos_q.x - 1'b1;
      end
      default: begin
        off_grid = (pos_q.x == X_LAST);
        tgt.x    = pos_q.x + 1'b1;
      end
    endcase
    lin  = 16'(tgt.y) * 16'(MAZE_W) + 16'(tgt.x);
    wall = 1'b1;
    if (!off_grid && (lin < 16'(CELLS))) begin
      wall = maze[lin[IDX_W-1:0]];
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOAD: begin
        pos_d   = start_pos;
        state_d = (start_pos == end_pos) ? ST_WON : ST_IDLE;
      end
      ST_IDLE: begin
        if (p_up || p_down || p_left || p_right) begin
          state_d = ST_CHECK;
          if (p_up)        dir_d = DIR_UP;
          else if (p_down) dir_d = DIR_DOWN;
          else if (p_left) dir_d = DIR_LEFT;
          else             dir_d = DIR_RIGHT;
        end
      end
      ST_CHECK: begin
        if (off_grid || wall) begin
          state_d = ST_IDLE;
        end else begin
          // Position and count land on entry to COMMIT so they are visible two cycles after the pulse.
          pos_d   = tgt;
          cnt_d   = (cnt_q == MOVES_MAX) ? cnt_q : cnt_q + 1'b1;
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = (pos_q == end_pos) ? ST_WON : ST_IDLE;
      end
      ST_WON: begin
        state_d = ST_WON;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD;
      dir_q   <= DIR_UP;
      pos_q   <= '0;
      cnt_q   <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      win_q   <= (state_d == ST_WON);
    end
  end

  assign player_pos = pos_q;
  assign win        = win_q;
  assign move_count = cnt_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl on a 10x10 bordered maze with DEB_CYCLES=4.
module tb_player_ctrl;

  localparam int W   = 10;
  localparam int H   = 10;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W*H-1:0] maze = '0;
  logic [7:0]   start_pos = 8'h11;
  logic [7:0]   end_pos = 8'h88;
  logic         btn_up = 1'b0;
  logic         btn_down = 1'b0;
  logic         btn_left = 1'b0;
  logic         btn_right = 1'b0;
  logic [7:0]   player_pos;
  logic         win;
  logic [9:0]   move_count;

  logic [W*H-1:0] maze_a;
  logic [W*H-1:0] maze_b;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  player_ctrl #(.MAZE_W(W), .MAZE_H(H), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .maze(maze), .start_pos(start_pos), .end_pos(end_pos),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .player_pos(player_pos), .win(win), .move_count(move_count)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the chosen buttons for 10 cycles, release, and let the release settle.
  task automatic press(input logic u, input logic d, input logic l, input logic r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    step(10);
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    step(12);
  endtask

  task automatic do_reset(input logic [7:0] s, input logic [7:0] e, input logic [W*H-1:0] m);
    start_pos = s; end_pos = e; maze = m;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    start_pos = 8'h11; end_pos = 8'h88; maze = maze_a;
    reset = 1'b1;
    step(3);
    compared++; if (player_pos !== 8'h00) begin mismatched++; $display("FAIL reset_pos: got %h expected %h", player_pos, 8'h00); end
    compared++; if (win !== 1'b0) begin mismatched++; $display("FAIL reset_win: got %b expected 0", win); end
    compared++; if (move_count !== 10'd0) begin mismatched++; $display("FAIL reset_count: got %0d expected 0", move_count); end
    reset = 1'b0;
    step(1);
    compared++; if (player_pos !== 8'h11) begin mismatched++; $display("FAIL load_pos: got %h expected %h", player_pos, 8'h11); end
    compared++; if (win !== 1'b0) begin mismatched++; $display("FAIL load_win: got %b expected 0", win); end
    compared++; if (move_count !== 10'd0) begin mismatched++; $display("FAIL load_count: got %0d expected 0", move_count); end
  endtask

  task automatic test_move_latency();
    btn_right = 1'b1;
    step(8);
    compared++; if (player_pos !== 8'h11) begin mismatched++; $display("FAIL latency_early: got %h expected %h", player_pos, 8'h11); end
    step(1);
    compared++; if (player_pos !== 8'h21) begin mismatched++; $display("FAIL latency_move: got %h expected %h", player_pos, 8'h21); end
    compared++; if (move_count !== 10'd1) begin mismatched++; $display("FAIL latency_count: got %0d expected 1", move_count); end
    step(1);
    btn_right = 1'b0;
    step(12);
    compared++; if (player_pos !== 8'h21) begin mismatched++; $display("FAIL release_pos: got %h expected %h", player_pos, 8'h21); end
    compared++; if (move_count !== 10'd1) begin mismatched++; $display("FAIL release_count: got %0d expected 1", move_count); end
  endtask

  task automatic test_blocked();
    press(1'b0, 1'b1, 1'b0, 1'b0);
    compared++; if (player_pos !== 8'h22) begin mismatched++; $display("FAIL down_pos: got %h expected %h", player_pos, 8'h22); end
    press(1'b0, 1'b0, 1'b0, 1'b1);
    compared++; if (player_pos !== 8'h22) begin mismatched++; $display("FAIL wall_pos: got %h expected %h", player_pos, 8'h22); end
    compared++; if (move_count !== 10'd2) begin mismatched++; $display("FAIL wall_count: got %0d expected 2", move_count); end
  endtask

  task automatic test_priority();
    press(1'b1, 1'b0, 1'b1, 1'b0);
    compared++; if (player_pos !== 8'h21) begin mismatched++; $display("FAIL prio_pos: got %h expected %h", player_pos, 8'h21); end
    compared++; if (move_count !== 10'd3) begin mismatched++; $display("FAIL prio_count: got %0d expected 3", move_count); end
  endtask

  task automatic test_win();
    for (int i = 0; i < 6; i++) press(1'b0, 1'b0, 1'b0, 1'b1);
    compared++; if (player_pos !== 8'h81) begin mismatched++; $display("FAIL row_pos: got %h expected %h", player_pos, 8'h81); end
    for (int i = 0; i < 6; i++) press(1'b0, 1'b1, 1'b0, 1'b0);
    compared++; if (player_pos !== 8'h87) begin mismatched++; $display("FAIL col_pos: got %h expected %h", player_pos, 8'h87); end
    compared++; if (move_count !== 10'd15) begin mismatched++; $display("FAIL col_count: got %0d expected 15", move_count); end
    btn_down = 1'b1;
    step(9);
    compared++; if (player_pos !== 8'h88) begin mismatched++; $display("FAIL goal_pos: got %h expected %h", player_pos, 8'h88); end
    compared++; if (win !== 1'b0) begin mismatched++; $display("FAIL win_early: got %b expected 0", win); end
    step(1);
    compared++; if (win !== 1'b1) begin mismatched++; $display("FAIL win_set: got %b expected 1", win); end
    compared++; if (move_count !== 10'd16) begin mismatched++; $display("FAIL goal_count: got %0d expected 16", move_count); end
    btn_down = 1'b0;
    step(12);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    compared++; if (player_pos !== 8'h88) begin mismatched++; $display("FAIL won_hold_pos: got %h expected %h", player_pos, 8'h88); end
    compared++; if (move_count !== 10'd16) begin mismatched++; $display("FAIL won_hold_count: got %0d expected 16", move_count); end
    compared++; if (win !== 1'b1) begin mismatched++; $display("FAIL won_hold_win: got %b expected 1", win); end
    reset = 1'b1;
    step(1);
    compared++; if (win !== 1'b0) begin mismatched++; $display("FAIL rst_win: got %b expected 0", win); end
    compared++; if (player_pos !== 8'h00) begin mismatched++; $display("FAIL rst_pos: got %h expected %h", player_pos, 8'h00); end
    reset = 1'b0;
    step(1);
    compared++; if (player_pos !== 8'h11) begin mismatched++; $display("FAIL respawn_pos: got %h expected %h", player_pos, 8'h11); end
    compared++; if (move_count !== 10'd0) begin mismatched++; $display("FAIL respawn_count: got %0d expected 0", move_count); end
  endtask

  task automatic test_right_edge();
    do_reset(8'h95, 8'h88, maze_b);
    compared++; if (player_pos !== 8'h95) begin mismatched++; $display("FAIL edge_spawn: got %h expected %h", player_pos, 8'h95); end
    press(1'b0, 1'b0, 1'b0, 1'b1);
    compared++; if (player_pos !== 8'h95) begin mismatched++; $display("FAIL edge_pos: got %h expected %h", player_pos, 8'h95); end
    compared++; if (move_count !== 10'd0) begin mismatched++; $display("FAIL edge_count: got %0d expected 0", move_count); end
    btn_up = 1'b1;
    step(2);
    btn_up = 1'b0;
    step(15);
    compared++; if (player_pos !== 8'h95) begin mismatched++; $display("FAIL glitch_pos: got %h expected %h", player_pos, 8'h95); end
    compared++; if (move_count !== 10'd0) begin mismatched++; $display("FAIL glitch_count: got %0d expected 0", move_count); end
    press(1'b1, 1'b0, 1'b0, 1'b0);
    compared++; if (player_pos !== 8'h94) begin mismatched++; $display("FAIL edge_up_pos: got %h expected %h", player_pos, 8'h94); end
    compared++; if (move_count !== 10'd1) begin mismatched++; $display("FAIL edge_up_count: got %0d expected 1", move_count); end
  endtask

  task automatic test_start_is_end();
    do_reset(8'h44, 8'h44, maze_a);
    compared++; if (win !== 1'b1) begin mismatched++; $display("FAIL spawn_win: got %b expected 1", win); end
    compared++; if (player_pos !== 8'h44) begin mismatched++; $display("FAIL spawn_win_pos: got %h expected %h", player_pos, 8'h44); end
    press(1'b0, 1'b0, 1'b0, 1'b1);
    compared++; if (player_pos !== 8'h44) begin mismatched++; $display("FAIL spawn_win_hold: got %h expected %h", player_pos, 8'h44); end
    compared++; if (move_count !== 10'd0) begin mismatched++; $display("FAIL spawn_win_count: got %0d expected 0", move_count); end
  endtask

  initial begin
    maze_a = '0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (x == 0 || x == W - 1 || y == 0 || y == H - 1) maze_a[y*W+x] = 1'b1;
      end
    end
    maze_a[2*W+3] = 1'b1;
    // Right border removed and (0,6) opened, so a wrapped right move from (9,5) would find an open cell.
    maze_b = maze_a;
    for (int y = 0; y < H; y++) maze_b[y*W+(W-1)] = 1'b0;
    maze_b[6*W+0] = 1'b0;

    test_reset();
    test_move_latency();
    test_blocked();
    test_priority();
    test_win();
    test_right_edge();
    test_start_is_end();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
